// File: rtl/load_align_unit.sv
// load_align_unit: in-order load-return queue that aligns and extends memory read data (option: MISALIGN_TRAP_EN)
module load_align_unit #(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_addr_lsb,
  input  logic [2:0]      i_req_func3,
  input  logic [RD_W-1:0] i_req_rd,
  input  logic            i_rsp_valid,
  input  logic [31:0]     i_rsp_data,
  output logic            o_wb_valid,
  output logic [31:0]     o_wb_data,
  output logic [RD_W-1:0] o_wb_rd,
  output logic            o_wb_err,
  output logic            o_orphan,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + RD_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push, pop, mis;
  logic [1:0]      lsb;
  logic [2:0]      f3;
  logic [RD_W-1:0] rd;
  logic [7:0]      byte_v;
  logic [15:0]     half_v;
  logic [31:0]     ext;
  assign o_req_ready = o_count != FULL;
  assign push = i_req_valid && o_req_ready;
  assign pop  = i_rsp_valid && o_count != '0;
  assign {lsb, f3, rd} = mem[rd_ptr];
  // Select the addressed byte/half of the head entry and extend it
  always_comb begin
    byte_v = 8'(i_rsp_data >> {lsb, 3'b000});
    half_v = lsb[1] ? i_rsp_data[31:16] : i_rsp_data[15:0];
    ext = f3[1:0] == 2'b00 ? {{24{~f3[2] & byte_v[7]}}, byte_v} :
          f3[1:0] == 2'b01 ? {{16{~f3[2] & half_v[15]}}, half_v} : i_rsp_data;
  end
`ifdef MISALIGN_TRAP_EN
  assign mis = (f3[1:0] == 2'b01 && lsb[0]) || (f3 == 3'b010 && lsb != 2'b00);
`else
  assign mis = 1'b0;
`endif
  // Queue storage needs no reset; validity is tracked by the count
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= {i_req_addr_lsb, i_req_func3, i_req_rd};
  // Pointers, occupancy and the registered writeback
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_wb_valid <= 1'b0;
      o_wb_data  <= '0;
      o_wb_rd    <= '0;
      o_wb_err   <= 1'b0;
      o_orphan   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      o_count    <= o_count + (AW+1)'(push) - (AW+1)'(pop);
      o_wb_valid <= pop;
      o_orphan   <= i_rsp_valid && o_count == '0;
      if (pop) begin
        o_wb_data <= mis ? 32'h0 : ext;
        o_wb_rd   <= rd;
        o_wb_err  <= mis;
      end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit: directed checks of alignment, ordering, orphans and wrap
module tb_load_align_unit;
  logic        clk = 0, rst_n = 0;
  logic        req_valid = 0, rsp_valid = 0;
  logic [1:0]  lsb = 0;
  logic [2:0]  f3 = 0;
  logic [4:0]  rd_in = 0;
  logic [31:0] rsp_data = 0;
  logic        req_ready, wb_valid, wb_err, orphan;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic [2:0]  count;
  int n_cmp = 0, n_err = 0;
  logic [4:0] exp_q[$];
  logic [4:0] e_rd;

  load_align_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_addr_lsb(lsb), .i_req_func3(f3), .i_req_rd(rd_in),
    .i_rsp_valid(rsp_valid), .i_rsp_data(rsp_data),
    .o_wb_valid(wb_valid), .o_wb_data(wb_data), .o_wb_rd(wb_rd),
    .o_wb_err(wb_err), .o_orphan(orphan), .o_count(count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [1:0] l, input logic [2:0] f,
                      input logic [4:0] r, input logic sv, input logic [31:0] d);
    @(negedge clk);
    req_valid = rv; lsb = l; f3 = f; rd_in = r; rsp_valid = sv; rsp_data = d;
    @(posedge clk);
    #1;
    req_valid = 0; rsp_valid = 0;
  endtask

  task automatic wb(input string tag, input logic [4:0] r, input logic [31:0] d, input logic e);
    chk({tag, "_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, "_rd"}, 32'(wb_rd), 32'(r));
    chk({tag, "_data"}, wb_data, d);
    chk({tag, "_err"}, 32'(wb_err), 32'(e));
  endtask

  initial begin
    #2;
    chk("rst_valid", 32'(wb_valid), 0);
    chk("rst_data", wb_data, 0);
    chk("rst_rd", 32'(wb_rd), 0);
    chk("rst_err", 32'(wb_err), 0);
    chk("rst_orphan", 32'(orphan), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(req_ready), 1);
    @(negedge clk); rst_n = 1;
    // byte loads
    step(1, 2'b11, 3'b000, 5, 0, 0);
    chk("lb_count", 32'(count), 1);
    step(0, 0, 0, 0, 1, 32'h80FF_1234);
    wb("lb", 5, 32'hFFFF_FF80, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("hold_valid", 32'(wb_valid), 0);
    chk("hold_data", wb_data, 32'hFFFF_FF80);
    step(1, 2'b11, 3'b100, 6, 0, 0);
    step(0, 0, 0, 0, 1, 32'h80FF_1234);
    wb("lbu", 6, 32'h0000_0080, 0);
    step(1, 2'b01, 3'b000, 8, 0, 0);
    step(0, 0, 0, 0, 1, 32'h80FF_1234);
    wb("lb1", 8, 32'h0000_0012, 0);
    // half loads
    step(1, 2'b10, 3'b001, 7, 0, 0);
    step(0, 0, 0, 0, 1, 32'h8001_7FFF);
    wb("lh", 7, 32'hFFFF_8001, 0);
    step(1, 2'b00, 3'b101, 9, 0, 0);
    step(0, 0, 0, 0, 1, 32'h8001_7FFF);
    wb("lhu", 9, 32'h0000_7FFF, 0);
    // fill and ordering
    for (int i = 1; i <= 4; i++) step(1, 0, 3'b010, 5'(i), 0, 0);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(req_ready), 0);
    step(1, 0, 3'b010, 20, 1, 32'hA1);
    wb("full_pop", 1, 32'hA1, 0);
    chk("full_refuse_count", 32'(count), 3);
    for (int i = 2; i <= 4; i++) begin
      step(0, 0, 0, 0, 1, 32'hA0 + 32'(i));
      wb("drain", 5'(i), 32'hA0 + 32'(i), 0);
    end
    chk("drain_count", 32'(count), 0);
    // orphans
    step(0, 0, 0, 0, 1, 32'hDEAD);
    chk("orph_pulse", 32'(orphan), 1);
    chk("orph_novalid", 32'(wb_valid), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("orph_end", 32'(orphan), 0);
    step(1, 0, 3'b010, 11, 1, 32'h55);
    chk("same_cyc_orph", 32'(orphan), 1);
    chk("same_cyc_count", 32'(count), 1);
    chk("same_cyc_novalid", 32'(wb_valid), 0);
    step(0, 0, 0, 0, 1, 32'h66);
    wb("same_cyc_pop", 11, 32'h66, 0);
    step(1, 0, 3'b010, 12, 0, 0);
    step(1, 0, 3'b010, 13, 0, 0);
    chk("pre_rst_count", 32'(count), 2);
    @(negedge clk); rst_n = 0; #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_rd", 32'(wb_rd), 0);
    @(negedge clk); rst_n = 1;
    step(0, 0, 0, 0, 1, 32'h77);
    chk("rst_orph", 32'(orphan), 1);
    chk("rst_orph_valid", 32'(wb_valid), 0);
    chk("rst_orph_count", 32'(count), 0);
    // simultaneous push+pop and pointer wrap
    step(1, 0, 3'b010, 14, 0, 0); exp_q.push_back(14);
    step(1, 0, 3'b010, 15, 0, 0); exp_q.push_back(15);
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 3'b010, 5'(16 + i), 1, 32'h0101_0101 * 32'(i + 1));
      exp_q.push_back(5'(16 + i));
      e_rd = exp_q.pop_front();
      wb("wrap", e_rd, 32'h0101_0101 * 32'(i + 1), 0);
      chk("wrap_count", 32'(count), 2);
    end
    while (exp_q.size() > 0) begin
      step(0, 0, 0, 0, 1, 32'hC0DE);
      e_rd = exp_q.pop_front();
      wb("tail", e_rd, 32'hC0DE, 0);
    end
    chk("tail_count", 32'(count), 0);
    // misaligned accesses
`ifdef MISALIGN_TRAP_EN
    step(1, 2'b01, 3'b001, 3, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    wb("mis_lh", 3, 32'h0, 1);
    step(1, 2'b10, 3'b010, 4, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    wb("mis_lw", 4, 32'h0, 1);
    step(1, 2'b10, 3'b001, 6, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    wb("ali_lh", 6, 32'h0000_1234, 0);
`else
    step(1, 2'b01, 3'b001, 3, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    wb("mis_lh", 3, 32'h0000_5678, 0);
    step(1, 2'b10, 3'b010, 4, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1234_5678);
    wb("mis_lw", 4, 32'h1234_5678, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
